// File: rtl/ftdi_fifo_responder_pkg.sv
// ftdi_pkg: shared widths and FSM state types for the FTDI FIFO responder.
package ftdi_pkg;
  localparam int BYTE_W = 8;
  localparam int SYNC_STAGES = 2;
  typedef enum logic [1:0] {R_IDLE, R_DRIVE, R_RECOVER} rd_state_t;
  typedef enum logic [1:0] {W_IDLE, W_CAPTURE, W_RECOVER} wr_state_t;
endpackage

// File: rtl/ftdi_fifo_responder_if.sv
// ftdi_fifo_responder_if: host-side 245 FIFO bus plus local source/sink handshakes.
interface ftdi_fifo_responder_if;
  logic ftdi_rd;
  logic ftdi_wr;
  logic [ftdi_pkg::BYTE_W-1:0] adbus_in;
  logic [ftdi_pkg::BYTE_W-1:0] adbus_out;
  logic adbus_oe;
  logic rxf;
  logic txe;
  logic [ftdi_pkg::BYTE_W-1:0] src_data;
  logic src_valid;
  logic src_ready;
  logic [ftdi_pkg::BYTE_W-1:0] sink_data;
  logic sink_valid;
  logic sink_ready;
  modport master(
    output ftdi_rd, ftdi_wr, adbus_in, src_data, src_valid, sink_ready,
    input adbus_out, adbus_oe, rxf, txe, src_ready, sink_data, sink_valid
  );
  modport slave(
    input ftdi_rd, ftdi_wr, adbus_in, src_data, src_valid, sink_ready,
    output adbus_out, adbus_oe, rxf, txe, src_ready, sink_data, sink_valid
  );
endinterface

// File: rtl/ftdi_fifo_responder_fifo.sv
// byte_fifo: show-ahead byte queue with occupancy count.
module byte_fifo
  import ftdi_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic clock,
  input  logic reset_n,
  input  logic push,
  input  logic pop,
  input  logic [BYTE_W-1:0] data,
  output logic [BYTE_W-1:0] q,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic full,
  output logic empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [BYTE_W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic we, re;
  assign we = push && !full;
  assign re = pop && !empty;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign q = mem[rp];
  always_ff @(posedge clock) begin
    if (we) mem[wp] <= data;
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      wp <= wp + AW'(we);
      rp <= rp + AW'(re);
      count <= count + CW'(we) - CW'(re);
    end
  end
endmodule

// File: rtl/ftdi_fifo_responder.sv
// ftdi_fifo_responder: device side of the async 245 FIFO bus, answering RD#/WR#
// strobes from local rx/tx byte queues and flagging host protocol violations.
module ftdi_fifo_responder
  import ftdi_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int RECOVERY = 2
) (
  input  logic clock,
  input  logic reset_n,
  ftdi_fifo_responder_if.slave bus,
  output logic [$clog2(DEPTH+1)-1:0] rx_count,
  output logic [$clog2(DEPTH+1)-1:0] tx_count,
  output logic proto_err
);
  localparam int RW = $clog2(RECOVERY + 1);
  localparam int S = SYNC_STAGES;
  logic [S-1:0] rd_s, wr_s;
  logic [S-1:0][BYTE_W-1:0] din_s;
  logic rd_d, wr_d, rd_fall, rd_rise, wr_fall, wr_rise;
  rd_state_t rd_state, rd_nxt;
  wr_state_t wr_state, wr_nxt;
  logic [RW-1:0] rrec, rrec_nxt, wrec, wrec_nxt;
  logic [BYTE_W-1:0] hold, hold_nxt, dout, dout_nxt, rx_q, tx_q;
  logic oe, oe_nxt, rxf, rxf_nxt, txe, txe_nxt, err_nxt;
  logic rx_pop, tx_push, rx_full, rx_empty, tx_full, tx_empty;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_s <= '1;
      wr_s <= '1;
      din_s <= '0;
      rd_d <= 1'b1;
      wr_d <= 1'b1;
    end else begin
      rd_s <= {rd_s[S-2:0], bus.ftdi_rd};
      wr_s <= {wr_s[S-2:0], bus.ftdi_wr};
      din_s <= {din_s[S-2:0], bus.adbus_in};
      rd_d <= rd_s[S-1];
      wr_d <= wr_s[S-1];
    end
  end
  assign rd_fall = rd_d & ~rd_s[S-1];
  assign rd_rise = ~rd_d & rd_s[S-1];
  assign wr_fall = wr_d & ~wr_s[S-1];
  assign wr_rise = ~wr_d & wr_s[S-1];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_state <= R_IDLE;
      wr_state <= W_IDLE;
      rrec <= '0;
      wrec <= '0;
      hold <= '0;
      dout <= '0;
      oe <= 1'b0;
      rxf <= 1'b1;
      txe <= 1'b1;
      proto_err <= 1'b0;
    end else begin
      rd_state <= rd_nxt;
      wr_state <= wr_nxt;
      rrec <= rrec_nxt;
      wrec <= wrec_nxt;
      hold <= hold_nxt;
      dout <= dout_nxt;
      oe <= oe_nxt;
      rxf <= rxf_nxt;
      txe <= txe_nxt;
      proto_err <= err_nxt;
    end
  end

  // A same-cycle rd/wr fall lets the read proceed; the write is always the loser.
  always_comb begin
    rd_nxt = rd_state;
    wr_nxt = wr_state;
    rrec_nxt = rrec;
    wrec_nxt = wrec;
    hold_nxt = hold;
    dout_nxt = dout;
    oe_nxt = oe;
    err_nxt = proto_err;
    rx_pop = 1'b0;
    tx_push = 1'b0;
    case (rd_state)
      R_IDLE:
        if (rd_fall) begin
          if (wr_state != W_IDLE || rx_empty) err_nxt = 1'b1;
          else begin
            rd_nxt = R_DRIVE;
            oe_nxt = 1'b1;
            dout_nxt = rx_q;
          end
        end
      R_DRIVE:
        if (rd_rise) begin
          rx_pop = 1'b1;
          oe_nxt = 1'b0;
          rrec_nxt = '0;
          rd_nxt = R_RECOVER;
        end
      default:
        if (rrec == RW'(RECOVERY - 1)) rd_nxt = R_IDLE;
        else rrec_nxt = rrec + RW'(1);
    endcase
    case (wr_state)
      W_IDLE:
        if (wr_fall) begin
          if (rd_fall || rd_state != R_IDLE || tx_full) err_nxt = 1'b1;
          else begin
            wr_nxt = W_CAPTURE;
            hold_nxt = din_s[S-1];
          end
        end
      W_CAPTURE:
        if (wr_rise) begin
          tx_push = 1'b1;
          wrec_nxt = '0;
          wr_nxt = W_RECOVER;
        end
      default:
        if (wrec == RW'(RECOVERY - 1)) wr_nxt = W_IDLE;
        else wrec_nxt = wrec + RW'(1);
    endcase
    rxf_nxt = !(rd_nxt == R_IDLE && !rx_empty);
    txe_nxt = !(wr_nxt == W_IDLE && !tx_full);
  end

  byte_fifo #(.DEPTH(DEPTH)) rx_fifo (
    .clock(clock), .reset_n(reset_n),
    .push(bus.src_valid && !rx_full), .pop(rx_pop), .data(bus.src_data),
    .q(rx_q), .count(rx_count), .full(rx_full), .empty(rx_empty)
  );
  byte_fifo #(.DEPTH(DEPTH)) tx_fifo (
    .clock(clock), .reset_n(reset_n),
    .push(tx_push), .pop(bus.sink_ready && !tx_empty), .data(hold),
    .q(tx_q), .count(tx_count), .full(tx_full), .empty(tx_empty)
  );

  assign bus.adbus_out = dout;
  assign bus.adbus_oe = oe;
  assign bus.rxf = rxf;
  assign bus.txe = txe;
  assign bus.src_ready = !rx_full;
  assign bus.sink_data = tx_q;
  assign bus.sink_valid = !tx_empty;
endmodule

// File: doc/ftdi_fifo_responder.md
Name: ftdi_fifo_responder

Overview:
- Synthesizable model of the FTDI-chip side of the asynchronous 245-style FIFO bus: the device end that answers a host's RD#/WR# strobes and drives RXF#/TXE#.
- Used for FPGA loopback, for FPGA-to-FPGA links, and as the DUT partner in host-interface regression.
- Holds a byte queue for host reads, filled from a local source port.
- Holds a byte queue for host writes, drained to a local sink port.

Parameters:
- DEPTH, 16, entries per queue (power of 2, ≥2).
- RECOVERY, 2, clock cycles RXF#/TXE# stay high after a strobe's rising edge (emulates device precharge).

Ports:
- clock  in  1  system clock
- reset_n  in  1  async active-low reset
- ftdi_rd  in  1  host RD#, active low, asynchronous to clock
- ftdi_wr  in  1  host WR#, active low, asynchronous to clock
- adbus_in  in  8  data bus as driven by host
- adbus_out  out  8  data presented to host on reads
- adbus_oe  out  1  1 = responder drives the bus
- rxf  out  1  RXF#, low = byte available for host
- txe  out  1  TXE#, low = room for a host write
- src_data  in  8  byte to queue for host
- src_valid  in  1  src handshake
- src_ready  out  1  rx queue not full
- sink_data  out  8  byte received from host (queue head)
- sink_valid  out  1  tx queue non-empty
- sink_ready  in  1  sink handshake
- rx_count  out  $clog2(DEPTH+1)  bytes awaiting host read
- tx_count  out  $clog2(DEPTH+1)  bytes awaiting sink
- proto_err  out  1  sticky protocol-violation flag

Behaviour:
- Reset (async assert, sync release) values:
  - rxf=1, txe=1, adbus_oe=0, adbus_out=0.
  - sink_valid=0, rx_count=0, tx_count=0, proto_err=0.
  - src_ready=1 from first cycle after release.
  - Both queues emptied; both FSMs in IDLE.
- Inputs ftdi_rd, ftdi_wr and adbus_in each pass through a 2-flop synchronizer; synchronizer flops reset to 1 (strobes) and 0 (data).
- Falling/rising strobe edges are detected on the synchronized signal.
- Strobe sampled low at edge k → edge detected at edge k+2 → FSM acts and registered outputs valid after edge k+2.
- Local ports:
  - Push when src_valid&&src_ready.
  - Pop when sink_valid&&sink_ready.
  - A push on a full queue is impossible by handshake.
  - Simultaneous push and pop on the same queue keeps the count unchanged.
- Read FSM (R_IDLE, R_DRIVE, R_RECOVER):
  - rxf=0 only in R_IDLE with rx_count>0; rxf is registered, so the first src push makes rxf fall 1 cycle after the push edge.
  - R_IDLE, rd fall detected, rx_count>0 → R_DRIVE: adbus_oe=1, adbus_out=rx head, rxf=1.
  - R_IDLE, rd fall with rx_count==0 → set proto_err, stay in R_IDLE, bus not driven.
  - R_DRIVE, rd rise detected → pop rx head, adbus_oe=0 on the same edge, → R_RECOVER.
  - R_RECOVER holds rxf=1 for RECOVERY cycles, then → R_IDLE.
- Write FSM (W_IDLE, W_CAPTURE, W_RECOVER):
  - txe=0 only in W_IDLE with tx_count<DEPTH.
  - W_IDLE, wr fall detected, queue not full → capture synchronized adbus_in into a holding register, txe=1, → W_CAPTURE.
  - W_IDLE, wr fall when full → proto_err, no capture.
  - W_CAPTURE, wr rise detected → push holding register into tx queue, → W_RECOVER.
  - W_RECOVER holds txe=1 for RECOVERY cycles, then → W_IDLE.
- Bus exclusivity:
  - wr fall while read FSM is not in R_IDLE → ignored (no capture), proto_err set.
  - rd fall while write FSM is not in W_IDLE → ignored, proto_err set.
  - rd and wr falls detected in the same cycle → read wins, write ignored, proto_err set.
- proto_err clears only on reset.
- Reset mid-operation: adbus_oe drops immediately (async); a byte being driven is discarded with its queue.
- Host timing contract: strobe low ≥4 clocks, high ≥RECOVERY+3 clocks, and adbus_in stable from ≥3 clocks before WR# fall until WR# rise.

Decomposition:
- Package ftdi_pkg:
  - rd_state_t and wr_state_t enums.
  - BYTE_W=8.
  - SYNC_STAGES=2.
- Sub-module byte_fifo:
  - Parameter DEPTH.
  - Ports: push, pop, data, q, count, full, empty.
  - Show-ahead head, async active-low reset.
  - Instantiated twice (rx and tx queues).

Test Plan:
- Reset release → rxf=1, txe=0, adbus_oe=0, src_ready=1, counts 0; rxf still 1 ten cycles later.
- Push 0xA5,0x3C,0x7E via src → rx_count=3, rxf=0. Three host RD# pulses (5 clk low, 6 high) → adbus_out reads A5, 3C, 7E with adbus_oe=1 only inside each pulse. rxf=1 during each pulse and RECOVERY cycles after; rx_count ends 0 and rxf stays 1.
- sink_ready=0; host writes 0x00..0x0F → tx_count=16, txe=1 stays high. A 17th WR# pulse → proto_err=1, tx_count=16. Then sink_ready=1 → sink_data streams 0x00..0x0F in order, txe returns 0.
- RD# and WR# fall on the same clock with rx_count=1 → read completes with its byte, no tx push, proto_err=1.
- Simultaneous src push and host-read pop on the same edge → rx_count unchanged, data order preserved.
- reset_n low while adbus_oe=1 → adbus_oe=0 asynchronously, counts 0. After release, rxf=1 and txe=0.
